// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the SPI frame receiver.
package spi_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_PIX,
    ST_LABEL,
    ST_DONE_PIX,
    ST_DONE_LABEL,
    ST_ABORT
  } state_t;

  localparam int CMD_PIXEL = 0;
  localparam int CMD_LABEL = 1;

  // Keeps a 1-pixel build from collapsing the address port to zero width.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_bit_sampler.sv
// Synchronises MOSI/SCK/SS into clk, picks the sample edge and deserialises
// words. Everything is held cleared while SS is inactive, so a new SS fall always starts at bit 0.
module spi_bit_sampler #(
  parameter int WORD_BITS        = 8,
  parameter bit MSB_FIRST        = 1'b1,
  parameter bit CPHA_SAMPLE_FALL = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_mosi,
  input  logic                 i_sck,
  input  logic                 i_ss,
  output logic [WORD_BITS-1:0] o_word,
  output logic                 o_word_valid,
  output logic                 o_ss_active
);

  localparam int CW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

  logic [1:0]           r_mosi_s;
  logic [1:0]           r_sck_s;
  logic [1:0]           r_ss_s;
  logic                 r_sck_d;
  logic                 r_edge;
  logic                 r_bit;
  logic [CW-1:0]        r_cnt;
  logic [WORD_BITS-1:0] r_shift;
  logic                 r_wv;

  logic                 w_ss_active;
  logic                 w_edge;
  logic [WORD_BITS-1:0] w_shift_nx;

  // Synchronisers run through reset so SS is already settled when rst drops.
  always_ff @(posedge clk) begin
    r_mosi_s <= {r_mosi_s[0], i_mosi};
    r_sck_s  <= {r_sck_s[0], i_sck};
    r_ss_s   <= {r_ss_s[0], i_ss};
    r_sck_d  <= r_sck_s[1];
  end

  assign w_ss_active = ~r_ss_s[1];
  assign w_edge = (CPHA_SAMPLE_FALL ? (~r_sck_s[1] & r_sck_d)
                                    : (r_sck_s[1] & ~r_sck_d)) & w_ss_active;

  assign w_shift_nx = MSB_FIRST ? {r_shift[WORD_BITS-2:0], r_bit}
                                : {r_bit, r_shift[WORD_BITS-1:1]};

  // r_bit is captured alongside r_edge so MOSI changing right after the edge cannot leak in.
  always_ff @(posedge clk) begin
    if (rst || !w_ss_active) begin
      r_edge  <= 1'b0;
      r_bit   <= 1'b0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_wv    <= 1'b0;
    end else begin
      r_edge <= w_edge;
      r_bit  <= r_mosi_s[1];
      r_wv   <= 1'b0;
      if (r_edge) begin
        r_shift <= w_shift_nx;
        if (r_cnt == CW'(WORD_BITS - 1)) begin
          r_cnt <= '0;
          r_wv  <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_word       = r_shift;
  assign o_word_valid = r_wv;
  assign o_ss_active  = w_ss_active;

endmodule

// File: rtl/spi_frame_receiver.sv
// SPI slave frame front end: command word selects a pixel frame (addressed
// write strobes) or a label frame (one-hot label + calculate_cost pulse).
module spi_frame_receiver
  import spi_rx_pkg::*;
#(
  parameter int  WORD_BITS        = 8,
  parameter int  NUM_PIXELS       = 784,
  parameter int  NUM_CLASSES      = 10,
  parameter bit  MSB_FIRST        = 1'b1,
  parameter bit  CPHA_SAMPLE_FALL = 1'b0,
  localparam int AW               = addr_width(NUM_PIXELS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MOSI,
  input  logic                   SCK,
  input  logic                   SS,
  output logic [WORD_BITS-1:0]   pix_data,
  output logic [AW-1:0]          pix_addr,
  output logic                   pix_we,
  output logic                   frame_done,
  output logic [NUM_CLASSES-1:0] expected_label,
  output logic                   calculate_cost,
  output logic                   frame_error,
  output logic                   busy
);

  logic [WORD_BITS-1:0]   w_word;
  logic                   w_wv;
  logic                   w_ss_active;

  state_t                 r_state;
  state_t                 w_state_nx;
  logic                   r_ss_act_d;
  logic                   w_ss_fall;

  logic                   w_write;
  logic                   w_addr_clr;
  logic                   w_err_set;
  logic                   w_err_clr;
  logic                   w_lbl_load;
  logic [NUM_CLASSES-1:0] w_onehot;
  logic                   w_lbl_ok;

  logic [WORD_BITS-1:0]   r_pix_data;
  logic [AW-1:0]          r_addr;
  logic                   r_pix_we;
  logic                   r_frame_done;
  logic [NUM_CLASSES-1:0] r_label;
  logic                   r_cc;
  logic                   r_err;

  spi_bit_sampler #(
    .WORD_BITS       (WORD_BITS),
    .MSB_FIRST       (MSB_FIRST),
    .CPHA_SAMPLE_FALL(CPHA_SAMPLE_FALL)
  ) u_sampler (
    .clk         (clk),
    .rst         (rst),
    .i_mosi      (MOSI),
    .i_sck       (SCK),
    .i_ss        (SS),
    .o_word      (w_word),
    .o_word_valid(w_wv),
    .o_ss_active (w_ss_active)
  );

  // Reset value of 1 means an SS already low at reset release is not a fresh fall.
  assign w_ss_fall = w_ss_active & ~r_ss_act_d;

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      w_onehot[i] = (w_word == WORD_BITS'(i));
    end
    w_lbl_ok = |w_onehot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ss_act_d <= 1'b1;
    end else begin
      r_state    <= w_state_nx;
      r_ss_act_d <= w_ss_active;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_write    = 1'b0;
    w_addr_clr = 1'b0;
    w_err_set  = 1'b0;
    w_err_clr  = 1'b0;
    w_lbl_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ss_fall) w_state_nx = ST_CMD;
      end
      ST_CMD: begin
        if (!w_ss_active) begin
          w_state_nx = ST_IDLE;
          w_err_set  = 1'b1;
        end else if (w_wv) begin
          if (w_word == WORD_BITS'(CMD_PIXEL)) begin
            w_state_nx = ST_PIX;
            w_addr_clr = 1'b1;
            w_err_clr  = 1'b1;
          end else if (w_word == WORD_BITS'(CMD_LABEL)) begin
            w_state_nx = ST_LABEL;
            w_err_clr  = 1'b1;
          end else begin
            w_state_nx = ST_ABORT;
            w_err_set  = 1'b1;
          end
        end
      end
      ST_PIX: begin
        if (!w_ss_active) begin
          w_state_nx = ST_IDLE;
          w_err_set  = 1'b1;
        end else if (w_wv) begin
          w_write = 1'b1;
          if (r_addr == AW'(NUM_PIXELS - 1)) w_state_nx = ST_DONE_PIX;
        end
      end
      ST_LABEL: begin
        if (!w_ss_active) begin
          w_state_nx = ST_IDLE;
          w_err_set  = 1'b1;
        end else if (w_wv) begin
          if (w_lbl_ok) begin
            w_lbl_load = 1'b1;
            w_state_nx = ST_DONE_LABEL;
          end else begin
            w_err_set  = 1'b1;
            w_state_nx = ST_ABORT;
          end
        end
      end
      ST_DONE_PIX, ST_DONE_LABEL: w_state_nx = ST_ABORT;
      ST_ABORT: begin
        if (!w_ss_active) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Address advances the cycle after the strobe so pix_we sees the write address; it parks on the last pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix_we     <= 1'b0;
      r_pix_data   <= '0;
      r_addr       <= '0;
      r_frame_done <= 1'b0;
      r_cc         <= 1'b0;
      r_label      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_pix_we     <= w_write;
      r_frame_done <= (r_state == ST_DONE_PIX);
      r_cc         <= (r_state == ST_DONE_LABEL);
      if (w_write) r_pix_data <= w_word;
      if (w_addr_clr) begin
        r_addr <= '0;
      end else if (r_pix_we && (r_addr != AW'(NUM_PIXELS - 1))) begin
        r_addr <= r_addr + 1'b1;
      end
      if (w_lbl_load) r_label <= w_onehot;
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (w_err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign pix_data       = r_pix_data;
  assign pix_addr       = r_addr;
  assign pix_we         = r_pix_we;
  assign frame_done     = r_frame_done;
  assign expected_label = r_label;
  assign calculate_cost = r_cc;
  assign frame_error    = r_err;
  assign busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed bench: label/command vector table plus hand-written pixel, abort,
// reset and bit-order/edge/word-width sequences across three builds.
module tb_spi_frame_receiver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] ss, sck, mosi;

  logic [7:0]  pix_data0, pix_data1;
  logic [11:0] pix_data2;
  logic [9:0]  pix_addr0, pix_addr1;
  logic [1:0]  pix_addr2;
  logic [9:0]  label0, label1, label2;
  logic        we0, we1, we2, fd0, fd1, fd2, cc0, cc1, cc2;
  logic        err0, err1, err2, busy0, busy1, busy2;

  spi_frame_receiver u0 (
    .clk(clk), .rst(rst), .MOSI(mosi[0]), .SCK(sck[0]), .SS(ss[0]),
    .pix_data(pix_data0), .pix_addr(pix_addr0), .pix_we(we0), .frame_done(fd0),
    .expected_label(label0), .calculate_cost(cc0), .frame_error(err0), .busy(busy0)
  );

  spi_frame_receiver #(.MSB_FIRST(1'b0), .CPHA_SAMPLE_FALL(1'b1)) u1 (
    .clk(clk), .rst(rst), .MOSI(mosi[1]), .SCK(sck[1]), .SS(ss[1]),
    .pix_data(pix_data1), .pix_addr(pix_addr1), .pix_we(we1), .frame_done(fd1),
    .expected_label(label1), .calculate_cost(cc1), .frame_error(err1), .busy(busy1)
  );

  spi_frame_receiver #(.WORD_BITS(12), .NUM_PIXELS(4), .MSB_FIRST(1'b0),
                       .CPHA_SAMPLE_FALL(1'b1)) u2 (
    .clk(clk), .rst(rst), .MOSI(mosi[2]), .SCK(sck[2]), .SS(ss[2]),
    .pix_data(pix_data2), .pix_addr(pix_addr2), .pix_we(we2), .frame_done(fd2),
    .expected_label(label2), .calculate_cost(cc2), .frame_error(err2), .busy(busy2)
  );

  // ---------------- output monitors (own all event counters) ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int we_n0 = 0, bad0 = 0, fd_n0 = 0, cc_n0 = 0, gap0 = -1, last_we0 = 0, exp0 = 0;
  always @(negedge clk) begin
    if (!busy0) exp0 = 0;
    if (we0) begin
      we_n0++;
      if (pix_addr0 != exp0[9:0] || pix_data0 != exp0[7:0]) bad0++;
      exp0++;
      last_we0 = cyc;
    end
    if (fd0) begin
      fd_n0++;
      gap0 = cyc - last_we0;
    end
    if (cc0) cc_n0++;
  end

  int we_n1 = 0, fd_n1 = 0;
  logic [7:0] d1 [8];
  logic [9:0] a1 [8];
  always @(negedge clk) begin
    if (we1) begin
      if (we_n1 < 8) begin
        d1[we_n1] = pix_data1;
        a1[we_n1] = pix_addr1;
      end
      we_n1++;
    end
    if (fd1) fd_n1++;
  end

  int we_n2 = 0, fd_n2 = 0;
  logic [11:0] d2 [8];
  logic [1:0]  a2 [8];
  always @(negedge clk) begin
    if (we2) begin
      if (we_n2 < 8) begin
        d2[we_n2] = pix_data2;
        a2[we_n2] = pix_addr2;
      end
      we_n2++;
    end
    if (fd2) fd_n2++;
  end

  // ---------------- checking and SPI driving ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One SCK period is 4 clk; MOSI moves mid-low-phase so both edges see stable data.
  task automatic spi_bit(input int b, input logic v);
    @(negedge clk);
    mosi[b] = v;
    @(negedge clk);
    sck[b] = 1'b1;
    repeat (2) @(negedge clk);
    sck[b] = 1'b0;
  endtask

  task automatic send_word(input int b, input logic [15:0] val, input int nbits, input bit msb);
    for (int i = 0; i < nbits; i++) spi_bit(b, msb ? val[nbits-1-i] : val[i]);
  endtask

  task automatic ss_low(input int b);
    ss[b] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic ss_high(input int b);
    repeat (8) @(negedge clk);
    ss[b] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] arg;
    logic [9:0] exp_label;
    logic       exp_err;
    int         exp_cc;
  } vec_t;

  vec_t tbl [8];
  int   w0, f0, c0, b0;

  initial begin
    tbl[0] = '{8'h01, 8'h07, 10'h080, 1'b0, 1};
    tbl[1] = '{8'h05, 8'h03, 10'h080, 1'b1, 0};
    tbl[2] = '{8'h01, 8'h0C, 10'h080, 1'b1, 0};
    tbl[3] = '{8'h01, 8'h00, 10'h001, 1'b0, 1};
    tbl[4] = '{8'h01, 8'h09, 10'h200, 1'b0, 1};
    tbl[5] = '{8'h01, 8'h0A, 10'h200, 1'b1, 0};
    tbl[6] = '{8'h02, 8'h01, 10'h200, 1'b1, 0};
    tbl[7] = '{8'h01, 8'h03, 10'h008, 1'b0, 1};

    rst = 1'b1; ss = 3'b111; sck = 3'b000; mosi = 3'b000;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset pix_we",   {31'b0, we0},   0);
    chk("reset pix_addr", {22'b0, pix_addr0}, 0);
    chk("reset pix_data", {24'b0, pix_data0}, 0);
    chk("reset label",    {22'b0, label0}, 0);
    chk("reset error",    {31'b0, err0},  0);
    chk("reset busy",     {31'b0, busy0}, 0);

    // command / label vectors
    for (int k = 0; k < 8; k++) begin
      w0 = we_n0; c0 = cc_n0;
      ss_low(0);
      send_word(0, {8'h00, tbl[k].cmd}, 8, 1'b1);
      send_word(0, {8'h00, tbl[k].arg}, 8, 1'b1);
      ss_high(0);
      chk($sformatf("vec%0d label", k), {22'b0, label0}, {22'b0, tbl[k].exp_label});
      chk($sformatf("vec%0d error", k), {31'b0, err0}, {31'b0, tbl[k].exp_err});
      chk($sformatf("vec%0d cost pulses", k), cc_n0 - c0, tbl[k].exp_cc);
      chk($sformatf("vec%0d writes", k), we_n0 - w0, 0);
      chk($sformatf("vec%0d busy", k), {31'b0, busy0}, 0);
    end

    // full pixel frame, byte i = i[7:0], two trailing words ignored
    w0 = we_n0; f0 = fd_n0; b0 = bad0;
    ss_low(0);
    send_word(0, 16'h0000, 8, 1'b1);
    for (int i = 0; i < 784; i++) send_word(0, 16'(i & 255), 8, 1'b1);
    send_word(0, 16'h0000, 8, 1'b1);
    send_word(0, 16'h0055, 8, 1'b1);
    ss_high(0);
    chk("frame writes",      we_n0 - w0, 784);
    chk("frame bad writes",  bad0 - b0, 0);
    chk("frame done pulses", fd_n0 - f0, 1);
    chk("frame done gap",    gap0, 1);
    chk("frame error",       {31'b0, err0}, 0);
    chk("frame last addr",   {22'b0, pix_addr0}, 783);
    chk("frame last data",   {24'b0, pix_data0}, 32'h0F);
    chk("frame busy",        {31'b0, busy0}, 0);

    // SS rises after 100 pixels + 3 bits
    w0 = we_n0; f0 = fd_n0; b0 = bad0;
    ss_low(0);
    send_word(0, 16'h0000, 8, 1'b1);
    for (int i = 0; i < 100; i++) send_word(0, 16'(i), 8, 1'b1);
    send_word(0, 16'h0005, 3, 1'b1);
    ss_high(0);
    chk("abort writes",      we_n0 - w0, 100);
    chk("abort bad writes",  bad0 - b0, 0);
    chk("abort frame done",  fd_n0 - f0, 0);
    chk("abort error",       {31'b0, err0}, 1);
    chk("abort addr",        {22'b0, pix_addr0}, 100);
    chk("abort busy",        {31'b0, busy0}, 0);
    ss_low(0);
    send_word(0, 16'h0001, 8, 1'b1);
    send_word(0, 16'h0002, 8, 1'b1);
    ss_high(0);
    chk("post-abort error cleared", {31'b0, err0}, 0);
    chk("post-abort label", {22'b0, label0}, 32'h004);

    // rst in the middle of a pixel frame
    ss_low(0);
    send_word(0, 16'h0000, 8, 1'b1);
    for (int i = 0; i < 10; i++) send_word(0, 16'(i), 8, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst pix_we",   {31'b0, we0}, 0);
    chk("midrst pix_addr", {22'b0, pix_addr0}, 0);
    chk("midrst pix_data", {24'b0, pix_data0}, 0);
    chk("midrst label",    {22'b0, label0}, 0);
    chk("midrst busy",     {31'b0, busy0}, 0);
    w0 = we_n0;
    send_word(0, 16'h0000, 8, 1'b1);
    send_word(0, 16'h0007, 8, 1'b1);
    repeat (8) @(negedge clk);
    chk("midrst needs SS fall writes", we_n0 - w0, 0);
    chk("midrst needs SS fall busy",   {31'b0, busy0}, 0);
    ss_high(0);
    w0 = we_n0; f0 = fd_n0; b0 = bad0;
    ss_low(0);
    send_word(0, 16'h0000, 8, 1'b1);
    for (int i = 0; i < 784; i++) send_word(0, 16'(i & 255), 8, 1'b1);
    ss_high(0);
    chk("refill writes",     we_n0 - w0, 784);
    chk("refill bad writes", bad0 - b0, 0);
    chk("refill frame done", fd_n0 - f0, 1);
    chk("refill last addr",  {22'b0, pix_addr0}, 783);

    // LSB-first, falling-edge build
    ss_low(1);
    send_word(1, 16'h0000, 8, 1'b0);
    send_word(1, 16'h00A5, 8, 1'b0);
    send_word(1, 16'h001E, 8, 1'b0);
    ss_high(1);
    chk("lsb writes",  we_n1, 2);
    chk("lsb data0",   {24'b0, d1[0]}, 32'hA5);
    chk("lsb data1",   {24'b0, d1[1]}, 32'h1E);
    chk("lsb addr1",   {22'b0, a1[1]}, 1);
    chk("lsb short frame error", {31'b0, err1}, 1);
    chk("lsb frame done", fd_n1, 0);

    // 12-bit words, 4-pixel frame
    ss_low(2);
    send_word(2, 16'h0000, 12, 1'b0);
    send_word(2, 16'h00A5, 12, 1'b0);
    send_word(2, 16'h05A3, 12, 1'b0);
    send_word(2, 16'h0FFF, 12, 1'b0);
    send_word(2, 16'h0801, 12, 1'b0);
    ss_high(2);
    chk("w12 writes", we_n2, 4);
    chk("w12 data0",  {20'b0, d2[0]}, 32'h0A5);
    chk("w12 data1",  {20'b0, d2[1]}, 32'h5A3);
    chk("w12 data2",  {20'b0, d2[2]}, 32'hFFF);
    chk("w12 data3",  {20'b0, d2[3]}, 32'h801);
    chk("w12 addr3",  {30'b0, a2[3]}, 3);
    chk("w12 frame done", fd_n2, 1);
    chk("w12 error",  {31'b0, err2}, 0);
    chk("w12 busy",   {31'b0, busy2}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_frame_receiver.md
Name: spi_frame_receiver

Overview:
Parametrised SPI slave front end for the digit-recognizer datapath. It receives command-prefixed frames over MOSI/SCK/SS and deserialises words of configurable width and bit order. Pixel frames become addressed write strobes into the image buffer; label frames become a one-hot expected-label vector plus a calculate_cost pulse. Beyond single-frame receive, it adds selectable SPI mode, frame-length checking, abort on SS deassertion, and an error status.

Parameters:
WORD_BITS, 8, bits per SPI word (command, pixel and label words).
NUM_PIXELS, 784, pixel words per pixel frame.
NUM_CLASSES, 10, width of the one-hot label vector.
MSB_FIRST, 1, 1 = first SCK bit lands in word MSB; 0 = LSB first.
CPHA_SAMPLE_FALL, 0, 0 = sample MOSI on SCK rising edge; 1 = sample on falling edge.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
MOSI  in  1  serial data, asynchronous
SCK  in  1  serial clock, asynchronous
SS  in  1  slave select, active-low, asynchronous
pix_data  out  WORD_BITS  received pixel word
pix_addr  out  $clog2(NUM_PIXELS)  pixel index within frame
pix_we  out  1  one-cycle write strobe for pix_data/pix_addr
frame_done  out  1  one-cycle pulse after the last pixel write of a complete frame
expected_label  out  NUM_CLASSES  one-hot label, held until the next valid label
calculate_cost  out  1  one-cycle pulse when a new label is latched
frame_error  out  1  sticky error flag, cleared on the next valid command word
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Synchronisation: MOSI, SCK and SS each pass through a 2-flop synchroniser. The edge detector fires on the selected synchronised SCK edge, gated by synchronised SS low.
- Sampling: on each sample edge, the shift register takes synchronised MOSI at the MSB end or LSB end per MSB_FIRST. A bit counter wraps at WORD_BITS-1. On wrap, word_valid pulses for one cycle. word_valid is internal and occurs 1 clk after the edge.
- Reset: all outputs are 0, except expected_label = 0 (no class). The state is IDLE and all counters are 0.
- States: IDLE, CMD, PIX, LABEL, DONE_PIX, DONE_LABEL, ABORT.
  - IDLE → CMD when synchronised SS falls. The bit counter and shift register clear on SS fall.
  - CMD, on word_valid:
    - word == 0 → PIX, with pix_addr = 0 and frame_error cleared.
    - word == 1 → LABEL, with frame_error cleared.
    - any other value → ABORT, with frame_error set.
  - PIX, on word_valid: pix_we = 1 and pix_data = word for one cycle at the current pix_addr, then pix_addr increments. When the write is at address NUM_PIXELS-1, go to DONE_PIX.
  - LABEL, on word_valid:
    - word < NUM_CLASSES → expected_label is loaded with a one-hot vector (bit[word]) on the next clk, and the state goes to DONE_LABEL.
    - word ≥ NUM_CLASSES → frame_error is set, expected_label is unchanged, and the state goes to ABORT.
  - DONE_PIX: frame_done = 1 for one cycle, then ABORT-wait for SS high. DONE_LABEL does the same with calculate_cost.
  - ABORT holds (ignoring all edges) until synchronised SS is high, then goes to IDLE.
- SS rises in any state other than IDLE/ABORT/DONE_*: this is a mid-frame abort. frame_error is set, the partial word is discarded, and the state goes to IDLE next cycle. No pix_we or frame_done is issued. Pixel writes already issued stand.
- Extra words after a completed frame while SS is still low are ignored. They do not raise an error.
- Latency: the last SCK sample edge reaches the synchroniser, then +1 clk for edge detect, +1 clk for word_valid, then pix_we is registered on the following clk. Total latency is 4 clk ±1 from the raw SCK edge, fixed per build. frame_done follows the last pix_we by exactly 1 clk.
- SCK must be ≤ clk/4. Faster SCK is unsupported, and no detection of it is required.
- rst mid-frame returns to the reset state immediately. The next frame requires a fresh SS fall.

Decomposition:
- Package spi_rx_pkg: the state enum type, the CMD_PIXEL = 0 and CMD_LABEL = 1 constants, and a function giving the address width via $clog2.
- One sub-module, spi_bit_sampler. It contains the synchronisers, edge select per CPHA_SAMPLE_FALL, SS gating, the shift register honouring MSB_FIRST, and the bit counter. Its outputs are word and word_valid plus ss_active.
- The top level holds the FSM, pixel address counter, label decode and status.

Test Plan:
- Pixel frame with defaults: SS low, command 0x00, then 784 bytes where byte i = i[7:0] → 784 pix_we pulses with pix_addr 0..783 and matching data, one frame_done 1 clk after the last write, frame_error = 0.
- Label frame: command 0x01, label 0x07 → expected_label = 10'b0010000000, calculate_cost pulses once, busy returns to 0 after SS rises.
- Invalid input: command 0x05 → frame_error = 1, no writes. Label 0x0C → frame_error = 1, expected_label retains its previous value.
- Abort: SS rises after 100 pixels plus 3 bits → exactly 100 pix_we, no frame_done, frame_error = 1. A following valid label frame clears frame_error.
- Mode sweep: MSB_FIRST = 0 with CPHA_SAMPLE_FALL = 1, command 0x00 then pixel 0xA5 sent LSB-first on falling edges → pix_data = 0xA5. Repeat with WORD_BITS = 12 and NUM_PIXELS = 4.
- Reset in the middle of a pixel frame: assert rst after 10 pixels → all outputs 0, and a subsequent full frame starts again from pix_addr 0.
